// File: rtl/xge_pkt_pkg.sv
// Shared types and helpers for the xge_mac RX reader/checker.
// Holds the FSM encoding, byte-mask helpers and the loopback payload pattern.
package xge_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_ABORT = 2'd2
    } rx_state_e;

    localparam logic [15:0] PAT_A5 = 16'hA5A5;
    localparam logic [15:0] PAT_5A = 16'h5A5A;

    // Bit 7 of the mask is byte 0, which sits in data[63:56].
    function automatic logic [7:0] mod_to_mask(input logic [2:0] mod);
        logic [7:0] m;
        if (mod == 3'd0) m = 8'hFF;
        else             m = ~(8'hFF >> mod);
        return m;
    endfunction

    function automatic logic [3:0] mod_to_bytes(input logic [2:0] mod);
        return (mod == 3'd0) ? 4'd8 : {1'b0, mod};
    endfunction

    function automatic logic [63:0] pat_word(input logic [15:0] n, input logic [15:0] k);
        logic [63:0] w;
        if (k == 16'd0) w = {n, 16'h0000, ~n, PAT_A5};
        else            w = {n, k, n ^ PAT_5A, k};
        return w;
    endfunction

endpackage

// File: rtl/xge_pkt_rx_reader_if.sv
// xge_mac pkt_rx bus: the MAC drives data/framing, the reader drives the read enable.
interface xge_pkt_rx_reader_if;
    logic        pkt_rx_avail;
    logic        pkt_rx_ren;
    logic        pkt_rx_val;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_err;

    modport master (
        output pkt_rx_avail, pkt_rx_val, pkt_rx_data, pkt_rx_sop,
               pkt_rx_eop, pkt_rx_mod, pkt_rx_err,
        input  pkt_rx_ren
    );

    modport slave (
        input  pkt_rx_avail, pkt_rx_val, pkt_rx_data, pkt_rx_sop,
               pkt_rx_eop, pkt_rx_mod, pkt_rx_err,
        output pkt_rx_ren
    );
endinterface

// File: rtl/xge_sat_cnt.sv
// Saturating statistics counter; clear has priority over an increment in the same cycle.
module xge_sat_cnt #(
    parameter int W  = 16,
    parameter int AW = 1
) (
    input  logic          clk_156m25,
    input  logic          reset_156m25,
    input  logic          clr,
    input  logic          inc,
    input  logic [AW-1:0] amt,
    output logic [W-1:0]  cnt
);
    logic [W:0] sum;

    assign sum = {1'b0, cnt} + {{(W + 1 - AW){1'b0}}, amt};

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25 || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sum[W] ? {W{1'b1}} : sum[W-1:0];
        end
    end
endmodule

// File: rtl/xge_pkt_rx_reader.sv
// Drains frames from the xge_mac RX FIFO, checks framing, sequence and payload
// pattern, and keeps saturating statistics.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for pkt_rx_avail; any pkt_rx_val here is a stray word
// ST_READ  | ren asserted, words checked, timeout counter running
// ST_ABORT | one-cycle drop of a timed-out frame, then back to idle
module xge_pkt_rx_reader
    import xge_pkt_pkg::*;
#(
    parameter int MAX_WORDS   = 64,
    parameter int TIMEOUT_CYC = 1024,
    parameter bit CHECK_EN    = 1'b1
) (
    input  logic                clk_156m25,
    input  logic                reset_156m25,
    xge_pkt_rx_reader_if.slave  rx,
    input  logic                stat_clr,
    output logic [31:0]         pkt_good_cnt,
    output logic [31:0]         pkt_bad_cnt,
    output logic [47:0]         byte_cnt,
    output logic [15:0]         mac_err_cnt,
    output logic [15:0]         pat_err_cnt,
    output logic [15:0]         seq_err_cnt,
    output logic [15:0]         frm_err_cnt,
    output logic                busy
);
    localparam int          TW       = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [15:0] K_LAST   = 16'(MAX_WORDS - 1);

    rx_state_e   state;
    logic [TW-1:0] tmo_cnt;
    logic        in_frame;
    logic [15:0] k_q, frm_n, exp_seq;
    logic [31:0] frm_bytes;
    logic        bad_frm, bad_pat, bad_seq;

    logic        rx_word, start, stray_sop, no_sop, oversize, pat_miss, seq_miss;
    logic        eof, tmo, stray_idle, any_bad;
    logic        w_frm, w_pat, w_seq;
    logic [15:0] k_cur, n_cur;
    logic [63:0] exp_word, byte_mask;
    logic [7:0]  cmask;
    logic [31:0] w_bytes;

    assign rx.pkt_rx_ren = (state == ST_READ) && !(rx.pkt_rx_val && rx.pkt_rx_eop);
    assign busy          = (state != ST_IDLE);

    // A word with no frame open starts one, so a missing sop still gets checked.
    always_comb begin
        rx_word    = (state == ST_READ) && rx.pkt_rx_val;
        start      = rx_word && (rx.pkt_rx_sop || !in_frame);
        stray_sop  = rx_word && rx.pkt_rx_sop && in_frame;
        no_sop     = rx_word && !rx.pkt_rx_sop && !in_frame;
        k_cur      = start ? 16'd0 : k_q;
        n_cur      = start ? rx.pkt_rx_data[63:48] : frm_n;
        oversize   = rx_word && (k_cur > K_LAST);
        exp_word   = pat_word(n_cur, k_cur);
        cmask      = ((k_cur == 16'd0) ? 8'h3F : 8'hFF) &
                     (rx.pkt_rx_eop ? mod_to_mask(rx.pkt_rx_mod) : 8'hFF);
        byte_mask  = '0;
        for (int i = 0; i < 8; i++) byte_mask[8*i +: 8] = {8{cmask[i]}};
        pat_miss   = CHECK_EN && rx_word && (|(byte_mask & (rx.pkt_rx_data ^ exp_word)));
        seq_miss   = start && (rx.pkt_rx_data[63:48] != exp_seq);
        w_frm      = (!start && bad_frm) || stray_sop || no_sop || oversize;
        w_pat      = (!start && bad_pat) || pat_miss;
        w_seq      = (!start && bad_seq) || seq_miss;
        w_bytes    = (start ? 32'd0 : frm_bytes) +
                     (rx.pkt_rx_eop ? {28'd0, mod_to_bytes(rx.pkt_rx_mod)} : 32'd8);
        eof        = rx_word && rx.pkt_rx_eop;
        tmo        = (state == ST_READ) && !rx.pkt_rx_val && (tmo_cnt == '0);
        stray_idle = (state == ST_IDLE) && rx.pkt_rx_val;
        any_bad    = w_frm || w_pat || w_seq || rx.pkt_rx_err;
    end

    // Expected sequence is committed only at eop, so an aborted frame leaves it untouched.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            in_frame  <= 1'b0;
            k_q       <= '0;
            frm_n     <= '0;
            exp_seq   <= '0;
            frm_bytes <= '0;
            bad_frm   <= 1'b0;
            bad_pat   <= 1'b0;
            bad_seq   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_frame <= 1'b0;
                    if (rx.pkt_rx_avail) begin
                        state   <= ST_READ;
                        tmo_cnt <= TMO_LOAD;
                    end
                end
                ST_READ: begin
                    if (eof) begin
                        state    <= ST_IDLE;
                        in_frame <= 1'b0;
                        exp_seq  <= n_cur + 16'd1;
                    end else if (tmo) begin
                        state    <= ST_ABORT;
                        in_frame <= 1'b0;
                    end else if (rx_word) begin
                        tmo_cnt   <= TMO_LOAD;
                        in_frame  <= 1'b1;
                        k_q       <= (k_cur == 16'hFFFF) ? k_cur : k_cur + 16'd1;
                        frm_n     <= n_cur;
                        frm_bytes <= w_bytes;
                        bad_frm   <= w_frm;
                        bad_pat   <= w_pat;
                        bad_seq   <= w_seq;
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                ST_ABORT: begin
                    state    <= ST_IDLE;
                    in_frame <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    xge_sat_cnt #(.W(32), .AW(1)) u_good (
        .clk_156m25(clk_156m25), .reset_156m25(reset_156m25), .clr(stat_clr),
        .inc(eof && !any_bad), .amt(1'b1), .cnt(pkt_good_cnt));
    xge_sat_cnt #(.W(32), .AW(1)) u_bad (
        .clk_156m25(clk_156m25), .reset_156m25(reset_156m25), .clr(stat_clr),
        .inc((eof && any_bad) || tmo), .amt(1'b1), .cnt(pkt_bad_cnt));
    xge_sat_cnt #(.W(48), .AW(32)) u_bytes (
        .clk_156m25(clk_156m25), .reset_156m25(reset_156m25), .clr(stat_clr),
        .inc(eof), .amt(w_bytes), .cnt(byte_cnt));
    xge_sat_cnt #(.W(16), .AW(1)) u_mac (
        .clk_156m25(clk_156m25), .reset_156m25(reset_156m25), .clr(stat_clr),
        .inc(eof && rx.pkt_rx_err), .amt(1'b1), .cnt(mac_err_cnt));
    xge_sat_cnt #(.W(16), .AW(1)) u_pat (
        .clk_156m25(clk_156m25), .reset_156m25(reset_156m25), .clr(stat_clr),
        .inc(eof && w_pat), .amt(1'b1), .cnt(pat_err_cnt));
    xge_sat_cnt #(.W(16), .AW(1)) u_seq (
        .clk_156m25(clk_156m25), .reset_156m25(reset_156m25), .clr(stat_clr),
        .inc(eof && w_seq), .amt(1'b1), .cnt(seq_err_cnt));
    xge_sat_cnt #(.W(16), .AW(1)) u_frm (
        .clk_156m25(clk_156m25), .reset_156m25(reset_156m25), .clr(stat_clr),
        .inc((eof && w_frm) || tmo || stray_idle), .amt(1'b1), .cnt(frm_err_cnt));
endmodule

// File: tb/tb_xge_pkt_rx_reader.sv
// Directed bench for xge_pkt_rx_reader: a small MAC model answers pkt_rx_ren with
// hand-built pattern frames and the statistics are compared against hand-computed values.
module tb_xge_pkt_rx_reader;
    localparam int T_CYC = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stat_clr = 1'b0;
    logic [31:0] pkt_good_cnt, pkt_bad_cnt;
    logic [47:0] byte_cnt;
    logic [15:0] mac_err_cnt, pat_err_cnt, seq_err_cnt, frm_err_cnt;
    logic        busy;

    int nvec = 0;
    int nerr = 0;
    logic [63:0] fw [0:7];

    xge_pkt_rx_reader_if rx_if ();

    xge_pkt_rx_reader #(.MAX_WORDS(4), .TIMEOUT_CYC(T_CYC), .CHECK_EN(1'b1)) u_dut (
        .clk_156m25(clk), .reset_156m25(rst), .rx(rx_if), .stat_clr(stat_clr),
        .pkt_good_cnt(pkt_good_cnt), .pkt_bad_cnt(pkt_bad_cnt), .byte_cnt(byte_cnt),
        .mac_err_cnt(mac_err_cnt), .pat_err_cnt(pat_err_cnt), .seq_err_cnt(seq_err_cnt),
        .frm_err_cnt(frm_err_cnt), .busy(busy));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] tb_pat(input logic [15:0] n, input logic [15:0] k);
        if (k == 16'd0) return {n, 16'h0000, ~n, 16'hA5A5};
        return {n, k, n ^ 16'h5A5A, k};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        rx_if.pkt_rx_val  = 1'b0;
        rx_if.pkt_rx_sop  = 1'b0;
        rx_if.pkt_rx_eop  = 1'b0;
        rx_if.pkt_rx_mod  = 3'd0;
        rx_if.pkt_rx_err  = 1'b0;
        rx_if.pkt_rx_data = 64'd0;
        stat_clr          = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_if.pkt_rx_avail = 1'b0;
        idle_bus();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic build_frame(input logic [15:0] n, input int nw);
        for (int k = 0; k < nw; k++) fw[k] = tb_pat(n, 16'(k));
    endtask

    // MAC model: a word follows each cycle in which ren was high. stop_after>0
    // leaves the frame unfinished after that many words (last word still driven).
    task automatic send_frame(input int nw, input logic [2:0] mod, input logic err,
                              input logic clr_eop, input int stop_after);
        int   idx = 0;
        int   guard = 0;
        int   lim;
        logic r;
        lim = (stop_after > 0) ? stop_after : nw;
        rx_if.pkt_rx_avail = 1'b1;
        while (idx < lim && guard < 200) begin
            @(negedge clk);
            r = rx_if.pkt_rx_ren;
            if (r) rx_if.pkt_rx_avail = 1'b0;
            @(posedge clk);
            #1;
            idle_bus();
            if (r) begin
                rx_if.pkt_rx_val  = 1'b1;
                rx_if.pkt_rx_data = fw[idx];
                rx_if.pkt_rx_sop  = (idx == 0);
                rx_if.pkt_rx_eop  = (idx == nw - 1);
                rx_if.pkt_rx_mod  = (idx == nw - 1) ? mod : 3'd0;
                rx_if.pkt_rx_err  = (idx == nw - 1) ? err : 1'b0;
                stat_clr          = clr_eop && (idx == nw - 1);
                idx++;
            end
            guard++;
        end
        check("drain_words", 64'(idx), 64'(lim));
        if (stop_after == 0) begin
            @(negedge clk);
            check("ren_low_at_eop", 64'(rx_if.pkt_rx_ren), 64'd0);
            @(posedge clk);
            #1 idle_bus();
        end
    endtask

    initial begin
        rx_if.pkt_rx_avail = 1'b0;
        idle_bus();
        do_reset();

        @(negedge clk);
        check("rst_ren",  64'(rx_if.pkt_rx_ren), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_good", 64'(pkt_good_cnt), 64'd0);
        check("rst_bytes", 64'(byte_cnt), 64'd0);
        @(posedge clk); #1;

        // Three clean frames, sequence 0..2, 3 words each
        for (int s = 0; s < 3; s++) begin
            build_frame(16'(s), 3);
            send_frame(3, 3'd0, 1'b0, 1'b0, 0);
        end
        check("t1_good",  64'(pkt_good_cnt), 64'd3);
        check("t1_bytes", 64'(byte_cnt), 64'd72);
        check("t1_bad",   64'(pkt_bad_cnt), 64'd0);
        check("t1_seq",   64'(seq_err_cnt), 64'd0);
        check("t1_pat",   64'(pat_err_cnt), 64'd0);
        check("t1_frm",   64'(frm_err_cnt), 64'd0);
        check("t1_mac",   64'(mac_err_cnt), 64'd0);
        check("t1_busy",  64'(busy), 64'd0);

        // Corruption outside the mod mask is ignored; inside it is caught
        do_reset();
        build_frame(16'd0, 2);
        fw[1][39:32] = fw[1][39:32] ^ 8'hFF;
        send_frame(2, 3'd3, 1'b0, 1'b0, 0);
        check("t2_pat_masked", 64'(pat_err_cnt), 64'd0);
        check("t2_bytes",      64'(byte_cnt), 64'd11);
        check("t2_good",       64'(pkt_good_cnt), 64'd1);
        build_frame(16'd1, 2);
        fw[1][55:48] = fw[1][55:48] ^ 8'hFF;
        send_frame(2, 3'd3, 1'b0, 1'b0, 0);
        check("t2_pat_hit", 64'(pat_err_cnt), 64'd1);
        check("t2_bad",     64'(pkt_bad_cnt), 64'd1);
        check("t2_seq",     64'(seq_err_cnt), 64'd0);
        check("t2_bytes2",  64'(byte_cnt), 64'd22);

        // Sequence jump 1 -> 5 counts once, then resyncs to 6
        do_reset();
        build_frame(16'd0, 2); send_frame(2, 3'd0, 1'b0, 1'b0, 0);
        build_frame(16'd1, 2); send_frame(2, 3'd0, 1'b0, 1'b0, 0);
        build_frame(16'd5, 2); send_frame(2, 3'd0, 1'b0, 1'b0, 0);
        build_frame(16'd6, 2); send_frame(2, 3'd0, 1'b0, 1'b0, 0);
        check("t3_seq",  64'(seq_err_cnt), 64'd1);
        check("t3_good", 64'(pkt_good_cnt), 64'd3);
        check("t3_bad",  64'(pkt_bad_cnt), 64'd1);

        // MAC error at eop: bad frame, bytes still counted
        do_reset();
        build_frame(16'd0, 3);
        send_frame(3, 3'd5, 1'b1, 1'b0, 0);
        check("t4_mac",   64'(mac_err_cnt), 64'd1);
        check("t4_bad",   64'(pkt_bad_cnt), 64'd1);
        check("t4_good",  64'(pkt_good_cnt), 64'd0);
        check("t4_bytes", 64'(byte_cnt), 64'd21);

        // Timeout after sop: abort, then a clean frame is good
        do_reset();
        build_frame(16'd0, 3);
        send_frame(3, 3'd0, 1'b0, 1'b0, 1);
        @(posedge clk); #1 idle_bus();
        repeat (T_CYC - 1) @(posedge clk);
        @(negedge clk);
        check("t5_busy_before", 64'(busy), 64'd1);
        check("t5_frm_before",  64'(frm_err_cnt), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t5_busy_after", 64'(busy), 64'd0);
        check("t5_frm",        64'(frm_err_cnt), 64'd1);
        check("t5_bad",        64'(pkt_bad_cnt), 64'd1);
        check("t5_bytes",      64'(byte_cnt), 64'd0);
        @(posedge clk); #1;
        build_frame(16'd0, 2);
        send_frame(2, 3'd0, 1'b0, 1'b0, 0);
        check("t5_good_next", 64'(pkt_good_cnt), 64'd1);
        check("t5_bad_next",  64'(pkt_bad_cnt), 64'd1);
        check("t5_seq_next",  64'(seq_err_cnt), 64'd0);

        // Oversize counts once per frame; stat_clr at eop wins; reset mid-frame
        do_reset();
        build_frame(16'd0, 6);
        send_frame(6, 3'd0, 1'b0, 1'b0, 0);
        check("t6_frm",   64'(frm_err_cnt), 64'd1);
        check("t6_bad",   64'(pkt_bad_cnt), 64'd1);
        check("t6_bytes", 64'(byte_cnt), 64'd48);
        check("t6_pat",   64'(pat_err_cnt), 64'd0);
        build_frame(16'd1, 2);
        send_frame(2, 3'd0, 1'b0, 1'b1, 0);
        check("t6_clr_good",  64'(pkt_good_cnt), 64'd0);
        check("t6_clr_bad",   64'(pkt_bad_cnt), 64'd0);
        check("t6_clr_bytes", 64'(byte_cnt), 64'd0);
        check("t6_clr_frm",   64'(frm_err_cnt), 64'd0);
        build_frame(16'd2, 2);
        send_frame(2, 3'd0, 1'b0, 1'b0, 0);
        check("t6_good_after_clr", 64'(pkt_good_cnt), 64'd1);
        check("t6_seq_after_clr",  64'(seq_err_cnt), 64'd0);
        build_frame(16'd3, 3);
        send_frame(3, 3'd0, 1'b0, 1'b0, 2);
        rst = 1'b1;
        idle_bus();
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_ren",  64'(rx_if.pkt_rx_ren), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_good", 64'(pkt_good_cnt), 64'd0);
        check("t6_rst_bytes", 64'(byte_cnt), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
